// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: four requesters share one bitwise logic unit through a
// round-robin arbiter that feeds a single-entry registered result slot.
// Optional feature macro: LUA_GRANT_CNT_EN adds a saturating 16-bit grant_cnt
// output that counts accepted requests.
module logic_unit_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req_valid,
  output logic [3:0]         req_ready,
  input  logic [11:0]        req_op,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [1:0]         rsp_id,
  output logic               rsp_err
`ifdef LUA_GRANT_CNT_EN
  ,
  output logic [15:0]        grant_cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t      state_q;
  slot_state_t      state_d;
  logic [1:0]       last_grant;
  logic [3:0]       grant;
  logic [1:0]       grant_idx;
  logic             grant_found;
  logic             slot_free;
  logic             transfer;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] result;
  logic             result_err;

  // Round-robin search starting one past the last granted requester
  always_comb begin
    logic [1:0] idx;
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    idx         = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!grant_found && req_valid[idx]) begin
        grant[idx]  = 1'b1;
        grant_idx   = idx;
        grant_found = 1'b1;
      end
    end
  end

  // Slot can accept when empty or being drained this same cycle; nothing is granted in reset
  always_comb begin
    slot_free = (state_q == EMPTY) || rsp_ready;
    req_ready = (rst_n && slot_free) ? grant : 4'b0000;
    transfer  = |req_ready;
  end

  // Route the granted requester's opcode and operands to the shared logic unit
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant_idx == 2'(i)) begin
        sel_op = req_op[3*i +: 3];
        sel_a  = req_a[WIDTH*i +: WIDTH];
        sel_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  // Shared bitwise logic unit; opcode 111 is illegal and yields zero with an error flag
  always_comb begin
    result     = '0;
    result_err = 1'b0;
    case (sel_op)
      3'b000:  result = ~sel_a;
      3'b001:  result = sel_a & sel_b;
      3'b010:  result = sel_a | sel_b;
      3'b011:  result = ~(sel_a & sel_b);
      3'b100:  result = sel_a ^ sel_b;
      3'b101:  result = ~(sel_a | sel_b);
      3'b110:  result = ~(sel_a ^ sel_b);
      default: result_err = 1'b1;
    endcase
  end

  // Slot next-state: a transfer always fills it, otherwise a drain empties it
  always_comb begin
    state_d = state_q;
    if (transfer) begin
      state_d = FULL;
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // Slot state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Result payload and arbitration pointer only move on an accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data   <= '0;
      rsp_id     <= '0;
      rsp_err    <= 1'b0;
      last_grant <= 2'd3;
    end else if (transfer) begin
      rsp_data   <= result;
      rsp_id     <= grant_idx;
      rsp_err    <= result_err;
      last_grant <= grant_idx;
    end
  end

  assign rsp_valid = (state_q == FULL);

`ifdef LUA_GRANT_CNT_EN
  logic [15:0] grant_cnt_q;

  // Saturating count of accepted requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
    end else if (transfer && (grant_cnt_q != 16'hFFFF)) begin
      grant_cnt_q <= grant_cnt_q + 16'd1;
    end
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, operand/result bit width (1..32).
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  input  4  per-requester request strobe, bit i = requester i.
REQ-005 Port: req_ready  output  4  per-requester accept, at most one bit high per cycle.
REQ-006 Port: req_op  input  12  3-bit opcode per requester, requester i at [3i+2:3i].
REQ-007 Port: req_a  input  4*WIDTH  operand A per requester, requester i at [WIDTH*i+WIDTH-1:WIDTH*i].
REQ-008 Port: req_b  input  4*WIDTH  operand B per requester, same packing as req_a.
REQ-009 Port: rsp_valid  output  1  result slot holds a valid result.
REQ-010 Port: rsp_ready  input  1  downstream consumes result when high with rsp_valid.
REQ-011 Port: rsp_data  output  WIDTH  registered result.
REQ-012 Port: rsp_id  output  2  index of requester that produced rsp_data.
REQ-013 Port: rsp_err  output  1  opcode 3'b111 was issued; rsp_data is zero.

Function
REQ-014 Shared logic unit SHALL compute bitwise: 000 NOT a, 001 a AND b, 010 a OR b, 011 NAND, 100 XOR, 101 NOR, 110 XNOR, 111 zero with rsp_err=1.
REQ-015 One-entry output slot; states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-016 Slot free this cycle = EMPTY, or FULL with rsp_ready=1 (same-cycle drain and refill allowed).
REQ-017 When slot free and any req_valid high, arbiter SHALL assert req_ready for exactly one valid requester, chosen round-robin starting at (last_grant+1) mod 4.
REQ-018 req_ready SHALL be combinational from req_valid, slot state, rsp_ready and last_grant; req_ready[i]=0 whenever req_valid[i]=0.
REQ-019 Transfer when req_valid[i]&req_ready[i]; at that edge rsp_data/rsp_id/rsp_err load, state->FULL, last_grant<=i. Latency: result visible one cycle after acceptance.
REQ-020 FULL with rsp_ready=0: rsp_data, rsp_id, rsp_err held stable; all req_ready=0.
REQ-021 FULL with rsp_ready=1 and no valid request: state->EMPTY; last_grant unchanged.
REQ-022 last_grant SHALL update only on transfer; a requester dropping req_valid without transfer has no effect.
REQ-023 Single active requester SHALL be granted every free cycle (no idle bubbles).
REQ-024 Four continuously-valid requesters with rsp_ready=1 SHALL be served in order 0,1,2,3,0,... from reset.
REQ-025 Results for WIDTH bits only; no carries, no cross-bit interaction.

Reset
REQ-026 rst_n low SHALL asynchronously force: state EMPTY, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, last_grant=3 (so first grant search starts at 0).
REQ-027 Reset asserted while FULL SHALL discard the pending result; no transfer occurs on the cycle of reset release edge while rst_n low.
REQ-028 req_ready SHALL be 0 while rst_n low.

Configuration
REQ-029 Macro LUA_GRANT_CNT_EN: when defined, add output port grant_cnt (16 bits) counting accepted requests, saturating at 16'hFFFF, reset to 0; when undefined, port and counter absent, all other behaviour identical.

Verification
REQ-030 WIDTH=8, only req 2 valid, op=001, a=8'hF0, b=8'h3C, rsp_ready=1 -> req_ready=4'b0100 same cycle; next cycle rsp_valid=1, rsp_data=8'h30, rsp_id=2.
REQ-031 All four valid continuously, op=100, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 on consecutive cycles, one result per cycle.
REQ-032 Req 0 accepted, then rsp_ready=0 for 3 cycles -> rsp_data/rsp_id stable, req_ready=4'b0000 for those 3 cycles; on rsp_ready=1, next request accepted same cycle.
REQ-033 op=111, a=8'hFF -> rsp_data=8'h00, rsp_err=1; following op=000, a=8'h0F -> rsp_data=8'hF0, rsp_err=0.
REQ-034 rst_n pulsed low while FULL with rsp_ready=0 -> rsp_valid=0 immediately (before next edge); after release, first grant goes to lowest valid index.
REQ-035 With LUA_GRANT_CNT_EN defined, 5 transfers -> grant_cnt=5; preloaded near 16'hFFFF, extra transfers -> holds 16'hFFFF.
